// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: default sizing, FSM encoding, mask helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
`ifndef LEN
`define LEN 4
`endif

package rr_arbiter_pkg;

    // Requester-index width; override at compile time with +define+LEN=<n>
    localparam int LEN_DEFAULT = `LEN;
    localparam int OPT_DEFAULT = 2**LEN_DEFAULT;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A requester is in the first-priority window when its index is at or above the pointer
    function automatic logic mask_bit(input int idx, input int ptr);
        return idx >= ptr;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
// Latency: n/a (wires only).
// Backpressure: a grant is held until the owner pulses ACK or drops its REQ bit.
interface rr_arbiter_if #(
    parameter int LEN = rr_arbiter_pkg::LEN_DEFAULT
);
    localparam int OPT = 2**LEN;

    logic [OPT-1:0] REQ;
    logic           ACK;
    logic [OPT-1:0] GNT;
    logic [LEN-1:0] GID;
    logic           VLD;

    modport master (output REQ, ACK, input GNT, GID, VLD);
    modport slave  (input REQ, ACK, output GNT, GID, VLD);
endinterface

// File: rtl/rr_arbiter_penc_lsb.sv
// Lowest-index priority encoder: Y is the index of the lowest set bit of X, V flags any bit set.
// Latency: purely combinational.
// Backpressure: none.
module penc_lsb #(
    parameter int LEN = 4
) (
    input  logic [2**LEN-1:0] X,
    output logic [LEN-1:0]    Y,
    output logic              V
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        Y = '0;
        V = 1'b0;
        for (int i = 2**LEN - 1; i >= 0; i--) begin
            if (X[i]) begin
                Y = i[LEN-1:0];
                V = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held until ACK or the owner drops REQ.
// Latency: grant 1 cycle after REQ; on release the next owner is granted the following cycle, no bubble.
// Backpressure: no preemption; other requesters wait until the current owner releases.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  bus
);

    localparam int OPT = 2**LEN;

    state_t         state_q, state_d;
    logic [LEN-1:0] ptr_q, ptr_d;
    logic [LEN-1:0] gid_q, gid_d;
    logic [OPT-1:0] gnt_q, gnt_d;
    logic           vld_q, vld_d;

    logic           rel;
    logic [LEN-1:0] arb_ptr;
    logic [OPT-1:0] mask;
    logic [OPT-1:0] req_masked;
    logic [LEN-1:0] y_masked, y_raw, win;
    logic           v_masked, v_raw;

    // Release when the owner acknowledges or withdraws; arbitration then sees the advanced pointer
    always_comb begin
        rel     = (state_q == BUSY) && (bus.ACK || !bus.REQ[gid_q]);
        arb_ptr = rel ? gid_q + LEN'(1) : ptr_q;
    end

    // First-priority window: indices at or above the arbitration pointer
    always_comb begin
        mask = '0;
        for (int i = 0; i < OPT; i++) begin
            mask[i] = mask_bit(i, int'(arb_ptr));
        end
        req_masked = bus.REQ & mask;
    end

    penc_lsb #(.LEN(LEN)) u_penc_masked (
        .X (req_masked),
        .Y (y_masked),
        .V (v_masked)
    );

    penc_lsb #(.LEN(LEN)) u_penc_raw (
        .X (bus.REQ),
        .Y (y_raw),
        .V (v_raw)
    );

    // Prefer the windowed winner; fall back to the lowest raw request when the window is empty
    always_comb win = v_masked ? y_masked : y_raw;

    // Next-state: grant from IDLE, hold in BUSY, hand over or go idle on release
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (v_raw) begin
                    state_d = BUSY;
                    gid_d   = win;
                    gnt_d   = OPT'(1) << win;
                    vld_d   = 1'b1;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d = arb_ptr;
                    if (v_raw) begin
                        gid_d = win;
                        gnt_d = OPT'(1) << win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    // State, pointer and registered outputs; rst wins over everything including an active grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.GNT = gnt_q;
    assign bus.GID = gid_q;
    assign bus.VLD = vld_q;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

    localparam int LEN = 2;
    localparam int OPT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbiter_if #(.LEN(LEN)) bus ();

    rr_arbiter #(.LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic           rst;
        logic [OPT-1:0] req;
        logic           ack;
        logic [OPT-1:0] gnt;
        logic [LEN-1:0] gid;
        logic           vld;
        logic           gid_chk;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0d: got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    // Inputs are applied, then one rising edge passes; outputs are read 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rotating search from the pointer: the first requester at or after ptr, wrapping around
    function automatic int pick(input logic [OPT-1:0] r, input int p);
        for (int k = 0; k < OPT; k++) begin
            int idx;
            idx = (p + k) % OPT;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        // rst, req, ack -> gnt, gid, vld, gid_chk
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1}; // reset
        vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1}; // idle, nothing asked
        vecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1}; // ptr=0 -> 1
        vecs[4]  = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1}; // ack, no bubble -> 3
        vecs[5]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1}; // held
        vecs[6]  = '{1'b0, 4'b1100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1}; // ptr wraps to 0 -> 2
        vecs[7]  = '{1'b0, 4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1}; // ptr=3, raw fallback -> 0
        vecs[8]  = '{1'b0, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1}; // ptr=1 -> 2
        vecs[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // owner drops, none pending
        vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1}; // ptr=3 -> 3
        vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1}; // fairness rotation
        vecs[12] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1}; // owner 0 drops -> 1
        vecs[17] = '{1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1}; // owner 1 drops -> 2
        vecs[18] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1}; // owner 2 drops -> 3
        vecs[19] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // none pending -> idle
        vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0}; // ack while idle ignored
        vecs[21] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1}; // ptr=0 -> 1
        vecs[22] = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1}; // lower index does not preempt
        vecs[23] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[24] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1}; // reset mid-grant
        vecs[25] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1}; // ptr back to 0 -> 0
        vecs[26] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1}; // single requester regranted
        vecs[27] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};

        bus.REQ = '0;
        bus.ACK = 1'b0;
        #2;

        // Directed table
        for (int v = 0; v < NV; v++) begin
            rst     = vecs[v].rst;
            bus.REQ = vecs[v].req;
            bus.ACK = vecs[v].ack;
            tick();
            chk("tbl_gnt", v, 32'(bus.GNT), 32'(vecs[v].gnt));
            chk("tbl_vld", v, 32'(bus.VLD), 32'(vecs[v].vld));
            if (vecs[v].gid_chk) chk("tbl_gid", v, 32'(bus.GID), 32'(vecs[v].gid));
        end

        // Hand-written: reset held for several cycles with requests pending keeps everything clear
        rst     = 1'b1;
        bus.REQ = 4'b1111;
        bus.ACK = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold_vld", c, 32'(bus.VLD), 32'd0);
        end
        rst     = 1'b0;
        bus.ACK = 1'b0;
        tick();
        chk("post_rst_gnt", 0, 32'(bus.GNT), 32'h1);
        // Hold without release for a while: grant must not move
        bus.REQ = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("hold_gnt", c, 32'(bus.GNT), 32'h1);
        end

        // Randomized run against a rotating-search reference model
        begin
            int             owner;
            int             ptr;
            logic [OPT-1:0] req;
            logic           ack;
            logic           r;
            logic [OPT-1:0] want_gnt;
            int             per_req [OPT];
            owner = -1;
            ptr   = 0;
            req   = '0;
            for (int i = 0; i < OPT; i++) per_req[i] = 0;
            for (int c = 0; c < 3000; c++) begin
                r = (c == 0) || ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 1) == 0) req = OPT'($urandom_range(0, OPT*OPT - 1));
                ack = ($urandom_range(0, 2) == 0);
                if (r) begin
                    owner = -1;
                    ptr   = 0;
                end else if (owner < 0) begin
                    owner = pick(req, ptr);
                end else if (ack || !req[owner]) begin
                    ptr   = (owner + 1) % OPT;
                    owner = pick(req, ptr);
                end
                rst     = r;
                bus.REQ = req;
                bus.ACK = ack;
                tick();
                want_gnt = '0;
                if (owner >= 0) begin
                    want_gnt[owner] = 1'b1;
                    per_req[owner]++;
                end
                chk("rnd_gnt", c, 32'(bus.GNT), 32'(want_gnt));
                chk("rnd_vld", c, 32'(bus.VLD), 32'(owner >= 0));
                if (owner >= 0) chk("rnd_gid", c, 32'(bus.GID), 32'(owner));
            end
            for (int i = 0; i < OPT; i++) begin
                total++;
                if (per_req[i] == 0) begin
                    bad++;
                    $display("FAIL rnd_starved requester=%0d got=0 grants want>0", i);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
